// File: rtl/rom_reader.sv
// ---------------------------------------------------------------------------
// rom_reader
//   Read-side initiator for a synchronous ROM with a registered read port
//   (one cycle of latency). On start it walks an address range from
//   first_addr up to last_addr inclusive. The address wraps from the top
//   of the ROM back to zero. Each word is delivered on a valid/ready stream,
//   and a running checksum of every delivered word is kept.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; rom_addr and checksum hold
//   WAIT    | ROM samples rom_addr at this edge
//   LATCH   | rom_data is valid; capture it into out_data
//   PRESENT | out_valid high until out_ready accepts the word
//   DONE    | done pulse for one cycle; busy drops on exit
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       scan request, sampled only in IDLE
//   abort       synchronous cancel of a running scan
//   first_addr  first scan address, sampled with start
//   last_addr   last scan address (inclusive), sampled with start
//   rom_addr    registered ROM address
//   rom_data    ROM read data, one cycle after rom_addr is sampled
//   out_data    delivered word
//   out_valid   out_data valid
//   out_ready   downstream accept
//   busy        scan in progress
//   done        one-cycle pulse after the last transfer
//   checksum    modular sum of the words transferred in the current or last scan
// ---------------------------------------------------------------------------
module rom_reader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4,
    parameter int CSUM_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [CSUM_W-1:0] checksum
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        LATCH   = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] rom_addr_d;
    logic [DATA_W-1:0] out_data_d;
    logic              out_valid_d;
    logic              busy_d;
    logic              done_d;
    logic [CSUM_W-1:0] checksum_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_q    <= '0;
            rom_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
        end else begin
            state     <= state_d;
            last_q    <= last_d;
            rom_addr  <= rom_addr_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            done      <= done_d;
            checksum  <= checksum_d;
        end
    end

    always_comb begin
        state_d     = state;
        last_d      = last_q;
        rom_addr_d  = rom_addr;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        busy_d      = busy;
        done_d      = 1'b0;
        checksum_d  = checksum;

        case (state)
            IDLE: begin
                if (start) begin
                    last_d     = last_addr;
                    rom_addr_d = first_addr;
                    checksum_d = '0;
                    busy_d     = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_data_d  = rom_data;
                    out_valid_d = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                // abort wins over a simultaneous handshake: the word is not counted
                if (abort) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else if (out_ready) begin
                    checksum_d  = checksum + CSUM_W'(out_data);
                    out_valid_d = 1'b0;
                    // rom_addr still holds the address of the word just transferred
                    if (rom_addr == last_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        rom_addr_d = rom_addr + ADDR_W'(1);
                        state_d    = WAIT;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rom_reader.sv
module tb_rom_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] first_addr;
    logic [2:0] last_addr;
    logic [2:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic [7:0] checksum;

    int checks = 0;
    int errors = 0;
    int done_cycles = 0;
    logic [3:0] exp_q[$];
    logic [3:0] rom_mem[8];

    always #5 clk = ~clk;

    rom_reader #(.ADDR_W(3), .DATA_W(4), .CSUM_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .checksum(checksum)
    );

    // ROM model with a registered read
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // Monitor: a handshake seen at the falling edge completes on the next rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cycles++;
            if (out_valid && out_ready && !abort) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word got %0h required none", out_data);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL word got %0h required %0h", out_data, e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] w);
        exp_q.push_back(w);
    endtask

    task automatic issue_start(input logic [2:0] f, input logic [2:0] l);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic finish_scan(input int d0, input logic [7:0] csum, input string name);
        int n;
        n = 0;
        while (done_cycles == d0 && n < 200) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, (n < 200) ? 1 : 0, 1);
        tick();
        tick();
        check({name, "_done_once"}, done_cycles - d0, 1);
        check({name, "_busy"}, busy, 0);
        check({name, "_csum"}, checksum, csum);
        check({name, "_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({name, "_valid_timeout"}, (n < 50) ? 1 : 0, 1);
    endtask

    initial begin
        int d0;
        rom_mem = '{4'h0, 4'h5, 4'hA, 4'hF, 4'h3, 4'h6, 4'h9, 4'hC};
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        first_addr = '0; last_addr = '0; out_ready = 1'b1;
        #12;
        check("rst_addr", rom_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_csum", checksum, 0);
        rst_n = 1'b1;
        tick();

        // full range 0..7
        d0 = done_cycles;
        foreach (rom_mem[i]) push(rom_mem[i]);
        issue_start(3'd0, 3'd7);
        check("s1_busy", busy, 1);
        finish_scan(d0, 8'h3C, "s1");

        // wrap 6..1
        d0 = done_cycles;
        push(4'h9); push(4'hC); push(4'h0); push(4'h5);
        issue_start(3'd6, 3'd1);
        finish_scan(d0, 8'h1A, "s2");

        // single word with latency check
        d0 = done_cycles;
        push(4'hF);
        issue_start(3'd3, 3'd3);
        check("s3_lat1", out_valid, 0);
        tick();
        check("s3_lat2", out_valid, 0);
        tick();
        check("s3_lat3", out_valid, 1);
        check("s3_data", out_data, 4'hF);
        finish_scan(d0, 8'h0F, "s3");

        // backpressure on word 2
        d0 = done_cycles;
        out_ready = 1'b0;
        push(4'h0); push(4'h5); push(4'hA); push(4'hF);
        issue_start(3'd0, 3'd3);
        for (int i = 0; i < 4; i++) begin
            wait_valid("s4");
            if (i == 2) begin
                for (int k = 0; k < 5; k++) begin
                    check("s4_hold_valid", out_valid, 1);
                    check("s4_hold_data", out_data, 4'hA);
                    check("s4_hold_addr", rom_addr, 2);
                    tick();
                end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        out_ready = 1'b1;
        finish_scan(d0, 8'h1E, "s4");

        // restart ignored mid-scan, abort after the second transfer
        d0 = done_cycles;
        push(4'h0); push(4'h5);
        issue_start(3'd0, 3'd7);      // E0 accepted
        first_addr = 3'd5; last_addr = 3'd5; start = 1'b1;
        tick();                       // E1
        tick();                       // E2 (start ignored)
        start = 1'b0;
        tick();                       // E3 transfer 0
        tick();
        tick();
        tick();                       // E6 transfer 5
        abort = 1'b1;
        tick();                       // E7 abort in WAIT
        abort = 1'b0;
        check("s5_valid", out_valid, 0);
        check("s5_busy", busy, 0);
        repeat (6) tick();
        check("s5_nodone", done_cycles - d0, 0);
        check("s5_csum", checksum, 8'h05);
        check("s5_left", exp_q.size(), 0);
        check("s5_valid_after", out_valid, 0);
        exp_q.delete();

        // abort takes priority over a simultaneous handshake
        push(4'hA);
        out_ready = 1'b0;
        issue_start(3'd2, 3'd3);
        wait_valid("s6");
        out_ready = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        exp_q.delete();               // the word must not be counted
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("s6_valid", out_valid, 0);
        check("s6_csum", checksum, 0);
        check("s6_busy", busy, 0);

        // async reset mid-scan
        d0 = done_cycles;
        push(4'h0);
        issue_start(3'd0, 3'd7);
        tick();
        tick();
        tick();                       // word 0 transferred
        tick();
        tick();                       // word 1 now presented
        #2;
        rst_n = 1'b0;
        #1;
        check("s7_addr", rom_addr, 0);
        check("s7_data", out_data, 0);
        check("s7_valid", out_valid, 0);
        check("s7_busy", busy, 0);
        check("s7_csum", checksum, 0);
        check("s7_left", exp_q.size(), 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("s7_nodone", done_cycles - d0, 0);
        d0 = done_cycles;
        push(4'hA); push(4'hF); push(4'h3);
        issue_start(3'd2, 3'd4);
        finish_scan(d0, 8'h1C, "s8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
